regs_arbiter: RTL
=================

// Module: regs_arbiter
// PURPOSE
//  Registered arbiter sharing the single TCPC register-file port among four clients: Tx, Rx, HReset, tcpm.
//  Fixed priority: tcpm > HReset > Rx > Tx. Each grant is held for one whole transaction, up to the register ACK.
//  Bus outputs stay stable while a transaction is in flight. Each client gets a one-cycle registered ACK and read data.
//  Sits between the protocol engines / port manager and the register bank.
// PARAMETERS
//  ADDR_W          8   register address width
//  DATA_W          8   register data width
//  TIMEOUT_CYCLES  16  BUSY cycles before abort (REGS_ARB_TIMEOUT_EN only)
//  CNT_W           5   timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  CLK                          in   1       clock, rising edge
//  RESET_n                      in   1       asynchronous active-low reset
//  REQ_Tx/_Rx/_HReset/_tcpm     in   1 ea    client request, level, held until ACK_x seen
//  RNW_Tx/_Rx/_HReset/_tcpm     in   1 ea    1 = read, 0 = write
//  ADDR_Tx/_Rx/_HReset/_tcpm    in   ADDR_W  client register address
//  WR_DATA_Tx/.../_tcpm         in   DATA_W  client write data
//  RD_DATA_Tx/.../_tcpm         out  DATA_W  per-client read data, registered, held until next read by that client
//  ACK_Tx/.../_tcpm             out  1 ea    one-cycle completion pulse to the granted client
//  REQUEST, RNW                 out  1       register-bank request / direction
//  ADDR                         out  ADDR_W  register-bank address
//  WR_DATA                      out  DATA_W  register-bank write data
//  ACK                          in   1       register-bank completion
//  RD_DATA                      in   DATA_W  register-bank read data, valid with ACK
//  BUSY                         out  1       1 in every state except IDLE
//  GNT                          out  2       granted client index (0=Tx, 1=Rx, 2=HReset, 3=tcpm); valid while BUSY
//  TIMEOUT_ERR                  out  1       one-cycle abort pulse
// BEHAVIOUR
//  Reset: every output is 0, including all RD_DATA_x. State goes to IDLE; any in-flight transaction is dropped, no ACK.
//  IDLE: at an edge with any REQ_x=1, pick the highest-priority requester.
//   - Latch GNT, ADDR, WR_DATA and RNW from that client, set REQUEST=1 and go to BUSY.
//   - Latency: REQ sampled at edge k gives REQUEST=1 in the cycle after edge k.
//  BUSY: bus outputs are frozen; changes on client inputs are ignored, including the granted client dropping REQ.
//   - Requests from higher-priority clients wait; there is no preemption.
//   - At an edge with ACK=1: REQUEST<=0 and ACK_<GNT><=1. If RNW=1, RD_DATA_<GNT><=RD_DATA; a write leaves it unchanged. Go to DONE.
//  DONE: exactly one cycle; ACK_<GNT>=1, all other ACK_x=0. Go to IDLE.
//   - The client must drop REQ at the edge that leaves DONE.
//   - A REQ still high in IDLE starts a new transaction (back-to-back allowed).
//  Minimum transaction: REQ to ACK_x is 3 cycles when the bank ACKs in its first BUSY cycle. There is one idle cycle between grants.
//  ACK while IDLE or DONE is ignored. All REQ_x rising together: tcpm wins; the others stay pending in priority order.
//  Only one ACK_x is ever high at a time. BUSY and GNT are registered from the state.
// CONFIGURATION
//  REGS_ARB_TIMEOUT_EN defined:
//   - Counter clears on entering BUSY and increments each BUSY cycle without ACK.
//   - When the counter reaches TIMEOUT_CYCLES: REQUEST<=0, ACK_<GNT><=1, RD_DATA_<GNT><=8'hFF on a read, TIMEOUT_ERR<=1 for that one DONE cycle, go to DONE.
//   - ACK and timeout on the same edge: ACK wins, no error.
//  Not defined: BUSY waits for ACK indefinitely; TIMEOUT_ERR is tied 0; no counter logic.
// STRUCTURE
//  Shared header regs_arb_pkg.vh holds:
//   - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2
//   - client indices CLI_TX=0, CLI_RX=1, CLI_HRESET=2, CLI_TCPM=3
//   - RD_ABORT_VAL=8'hFF
//  Sub-module regs_arb_prio_enc: combinational 4-bit request vector in, {valid, idx[1:0]} out.
//  Top level holds the FSM, the bus registers, per-client RD_DATA registers, ACK decode and the optional timeout counter.
// TESTING
//  1. Only REQ_Rx=1, RNW=1, ADDR=8'h10. Bank ACKs at BUSY cycle 2 with 8'hA5 -> GNT=1, ADDR=8'h10 stable, ACK_Rx pulse 1 cycle, RD_DATA_Rx=8'hA5.
//  2. REQ_Tx, REQ_Rx and REQ_tcpm rise on the same edge -> serviced tcpm, Rx, Tx. Single ACK pulses, one IDLE cycle between grants.
//  3. Tx granted on a write of 8'h3C to 8'h20. REQ_tcpm rises mid-BUSY and ADDR_Tx changes to 8'h55 -> bus keeps 8'h20/8'h3C; tcpm granted only after Tx DONE.
//  4. Bank never ACKs, macro defined, TIMEOUT_CYCLES=16, read -> at BUSY cycle 16: ACK_x and TIMEOUT_ERR pulse, RD_DATA_x=8'hFF. Macro undefined: BUSY stays high.
//  5. RESET_n low during BUSY -> all outputs 0 immediately and no ACK_x. After release with REQ held, a fresh grant starts.
//  6. Spurious ACK=1 while IDLE -> no ACK_x, no state change.

Source files
------------

// File: rtl/regs_arb_pkg.sv
// Shared definitions for the TCPC register-file arbiter: FSM state encoding,
// client indices, abort read value and the client one-hot decode helper.
package regs_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic [1:0] CLI_TX     = 2'd0;
    localparam logic [1:0] CLI_RX     = 2'd1;
    localparam logic [1:0] CLI_HRESET = 2'd2;
    localparam logic [1:0] CLI_TCPM   = 2'd3;

    localparam logic [7:0] RD_ABORT_VAL = 8'hFF;

    // One-hot select of a client from its index (bit i = client i).
    function automatic logic [3:0] cli_decode(input logic [1:0] idx);
        cli_decode = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/regs_arb_prio_enc.sv
// Fixed-priority request encoder: tcpm > HReset > Rx > Tx.
// Purely combinational; valid is set when any request bit is high.
module regs_arb_prio_enc
    import regs_arb_pkg::*;
(
    input  logic [3:0] req,
    output logic       valid,
    output logic [1:0] idx
);

    // Pick the highest-priority active requester.
    always_comb begin
        valid = (req != 4'b0000);
        idx   = CLI_TX;
        if (req[CLI_TCPM]) begin
            idx = CLI_TCPM;
        end else if (req[CLI_HRESET]) begin
            idx = CLI_HRESET;
        end else if (req[CLI_RX]) begin
            idx = CLI_RX;
        end else begin
            idx = CLI_TX;
        end
    end

endmodule

// File: rtl/regs_arbiter.sv
// Registered arbiter sharing one TCPC register-bank port among Tx, Rx,
// HReset and tcpm. A grant lasts for a whole transaction (IDLE -> BUSY ->
// DONE); bus outputs are frozen while BUSY.
// Optional feature: define REGS_ARB_TIMEOUT_EN to abort a transaction the
// bank does not acknowledge within TIMEOUT_CYCLES BUSY cycles.
module regs_arbiter
    import regs_arb_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              REQ_Tx,
    input  logic              REQ_Rx,
    input  logic              REQ_HReset,
    input  logic              REQ_tcpm,
    input  logic              RNW_Tx,
    input  logic              RNW_Rx,
    input  logic              RNW_HReset,
    input  logic              RNW_tcpm,
    input  logic [ADDR_W-1:0] ADDR_Tx,
    input  logic [ADDR_W-1:0] ADDR_Rx,
    input  logic [ADDR_W-1:0] ADDR_HReset,
    input  logic [ADDR_W-1:0] ADDR_tcpm,
    input  logic [DATA_W-1:0] WR_DATA_Tx,
    input  logic [DATA_W-1:0] WR_DATA_Rx,
    input  logic [DATA_W-1:0] WR_DATA_HReset,
    input  logic [DATA_W-1:0] WR_DATA_tcpm,
    output logic [DATA_W-1:0] RD_DATA_Tx,
    output logic [DATA_W-1:0] RD_DATA_Rx,
    output logic [DATA_W-1:0] RD_DATA_HReset,
    output logic [DATA_W-1:0] RD_DATA_tcpm,
    output logic              ACK_Tx,
    output logic              ACK_Rx,
    output logic              ACK_HReset,
    output logic              ACK_tcpm,
    output logic              REQUEST,
    output logic              RNW,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    input  logic              ACK,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              BUSY,
    output logic [1:0]        GNT,
    output logic              TIMEOUT_ERR
);

    // The timeout counter must be able to hold TIMEOUT_CYCLES - 1.
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("regs_arbiter: CNT_W too small for TIMEOUT_CYCLES");
    end

    arb_state_t        state_q, state_d;
    logic              request_q, request_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [3:0]        ack_q, ack_d;
    logic              terr_q, terr_d;
    logic [DATA_W-1:0] rd_data_q [4];
    logic [DATA_W-1:0] rd_data_d [4];

    logic [3:0]        req_vec_s;
    logic              pe_valid_s;
    logic [1:0]        pe_idx_s;
    logic              cli_rnw_s  [4];
    logic [ADDR_W-1:0] cli_addr_s [4];
    logic [DATA_W-1:0] cli_wd_s   [4];
    logic              timeout_s;

    assign req_vec_s = {REQ_tcpm, REQ_HReset, REQ_Rx, REQ_Tx};

    regs_arb_prio_enc u_prio_enc (
        .req   (req_vec_s),
        .valid (pe_valid_s),
        .idx   (pe_idx_s)
    );

    // Gather the per-client request fields into index-addressable arrays.
    always_comb begin
        cli_rnw_s[CLI_TX]      = RNW_Tx;
        cli_rnw_s[CLI_RX]      = RNW_Rx;
        cli_rnw_s[CLI_HRESET]  = RNW_HReset;
        cli_rnw_s[CLI_TCPM]    = RNW_tcpm;
        cli_addr_s[CLI_TX]     = ADDR_Tx;
        cli_addr_s[CLI_RX]     = ADDR_Rx;
        cli_addr_s[CLI_HRESET] = ADDR_HReset;
        cli_addr_s[CLI_TCPM]   = ADDR_tcpm;
        cli_wd_s[CLI_TX]       = WR_DATA_Tx;
        cli_wd_s[CLI_RX]       = WR_DATA_Rx;
        cli_wd_s[CLI_HRESET]   = WR_DATA_HReset;
        cli_wd_s[CLI_TCPM]     = WR_DATA_tcpm;
    end

`ifdef REGS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count BUSY cycles; the counter sits at zero outside BUSY so every
    // transaction starts counting from zero.
    always_comb begin
        if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        // Fires at the edge that ends the TIMEOUT_CYCLES-th BUSY cycle;
        // a bank ACK on the same edge takes precedence.
        timeout_s = (state_q == ST_BUSY) && !ACK &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Timeout counter register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/BUSY/DONE transaction FSM.
    always_comb begin
        state_d   = state_q;
        request_d = request_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        gnt_d     = gnt_q;
        ack_d     = 4'b0000;
        terr_d    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_data_d[i] = rd_data_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (pe_valid_s) begin
                    gnt_d     = pe_idx_s;
                    rnw_d     = cli_rnw_s[pe_idx_s];
                    addr_d    = cli_addr_s[pe_idx_s];
                    wr_data_d = cli_wd_s[pe_idx_s];
                    request_d = 1'b1;
                    state_d   = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ACK) begin
                    request_d = 1'b0;
                    ack_d     = cli_decode(gnt_q);
                    if (rnw_q) begin
                        rd_data_d[gnt_q] = RD_DATA;
                    end else begin
                        rd_data_d[gnt_q] = rd_data_q[gnt_q];
                    end
                    state_d = ST_DONE;
                end else if (timeout_s) begin
                    request_d = 1'b0;
                    ack_d     = cli_decode(gnt_q);
                    terr_d    = 1'b1;
                    if (rnw_q) begin
                        rd_data_d[gnt_q] = DATA_W'(RD_ABORT_VAL);
                    end else begin
                        rd_data_d[gnt_q] = rd_data_q[gnt_q];
                    end
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                request_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, bus, ACK and read-data registers.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            request_q <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            gnt_q     <= 2'd0;
            busy_q    <= 1'b0;
            ack_q     <= 4'b0000;
            terr_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rd_data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            request_q <= request_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            terr_q    <= terr_d;
            for (int i = 0; i < 4; i++) begin
                rd_data_q[i] <= rd_data_d[i];
            end
        end
    end

    assign REQUEST        = request_q;
    assign RNW            = rnw_q;
    assign ADDR           = addr_q;
    assign WR_DATA        = wr_data_q;
    assign GNT            = gnt_q;
    assign BUSY           = busy_q;
    assign TIMEOUT_ERR    = terr_q;
    assign ACK_Tx         = ack_q[CLI_TX];
    assign ACK_Rx         = ack_q[CLI_RX];
    assign ACK_HReset     = ack_q[CLI_HRESET];
    assign ACK_tcpm       = ack_q[CLI_TCPM];
    assign RD_DATA_Tx     = rd_data_q[CLI_TX];
    assign RD_DATA_Rx     = rd_data_q[CLI_RX];
    assign RD_DATA_HReset = rd_data_q[CLI_HRESET];
    assign RD_DATA_tcpm   = rd_data_q[CLI_TCPM];

endmodule
